pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the AZ stack CPU; successor to the single-cycle-branch PC. It takes one step per accepted `en` request. It supports sequential advance, unconditional and flag-conditional jumps, and CALL/RET through an internal return-address stack (RAS). Jump targets are popped from the data stack over a pop/valid handshake, so the data stack may take any number of cycles to respond.

Parameters:
INST_CAP, 20, instruction memory size; legal pc range is 0..INST_CAP-1
ADDR_W, $clog2(INST_CAP), pc width
DATA_LEN, 8, data-stack word width (jump target source)
RAS_DEPTH, 4, return-address stack entries (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
en  input  1  step request, sampled only in IDLE
op  input  3  000 NEXT, 001 JMP, 010 JZ, 011 JS, 100 CALL, 101 RET, 110 HALT, 111 reserved (= NEXT)
z_flag  input  1  zero flag, sampled in EXEC
s_flag  input  1  sign flag, sampled in EXEC
stk_pop  output  1  pop request to data stack
stk_valid  input  1  data-stack reply valid, qualifies stk_data
stk_data  input  DATA_LEN  popped jump target
pc  output  ADDR_W  current program counter
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, high in the cycle the new pc is first visible
halted  output  1  high in HALTED
err_ras  output  2  sticky {overflow, underflow}; cleared only by reset
err_tgt  output  1  sticky, set when a taken target is >= INST_CAP

Behaviour:
- Reset: async on rstn low, regardless of en. Resets state=IDLE, pc=0, stk_pop=0, done=0, halted=0, err_ras=0, err_tgt=0, RAS pointer=0. No output is ever driven to z.
- Reset mid-operation aborts immediately. A pending pop is dropped (stk_pop falls asynchronously). A stk_valid arriving after reset is ignored.
- States: IDLE, POP, EXEC, HALTED.
- IDLE:
  - en=1 with op in JMP/JZ/JS/CALL -> POP.
  - en=1 with NEXT/RET/reserved -> EXEC.
  - en=1 with HALT -> HALTED.
  - op is latched on acceptance. en is ignored while busy.
- POP:
  - stk_pop=1 for every cycle in POP.
  - On the edge where stk_valid=1: latch stk_data into target, go to EXEC. stk_pop is 0 in EXEC.
  - Conditional branches always pop, even when not taken.
- EXEC: exactly one cycle; updates pc on its closing edge, then -> IDLE with done=1 for that one IDLE cycle.
  - nxt = pc+1 if pc < INST_CAP-1, else pc (saturate).
  - NEXT/reserved: pc <= nxt.
  - JMP: pc <= target.
  - JZ: pc <= z_flag ? target : nxt.
  - JS: pc <= s_flag ? target : nxt.
  - CALL: if RAS not full, push nxt and set pc <= target. If full, set err_ras[1] and pc <= nxt (call not taken).
  - RET: if RAS not empty, pop and set pc <= top entry. If empty, set err_ras[0] and pc <= nxt.
  - Taken target >= INST_CAP: set err_tgt and pc <= nxt; for CALL, no push occurs.
  - Target width: the low ADDR_W bits of target are used. If DATA_LEN > ADDR_W, any nonzero upper bit counts as out of range. If DATA_LEN < ADDR_W, target is zero-extended.
- HALTED: pc frozen, halted=1, busy=1. Exited only by reset.
- Latency (en accepted at edge N):
  - NEXT/RET: pc updated and done=1 after edge N+1.
  - Branch: stk_pop rises after edge N. If stk_valid is seen at edge M (M>=N+1), pc is updated and done=1 after edge M+1.
- stk_valid outside POP is ignored.

Optional Feature:
PC_WRAP_EN: when defined, the sequential increment wraps INST_CAP-1 -> 0 instead of saturating; this applies to nxt in every op, including pushed return addresses. When undefined, nxt saturates at INST_CAP-1.

Test Plan:
- Reset, then three NEXT steps with en pulses -> pc 0,1,2,3; done pulses one cycle after each acceptance; busy high exactly one cycle per step.
- JZ with stk_valid delayed 3 cycles, stk_data=9, z_flag=1 -> stk_pop high 3 cycles, pc=9; repeat with z_flag=0 from pc=4 -> pc=5, pop still occurs.
- From pc=2, CALL with stk_data=12, then NEXT, then RET -> pc 12, 13, 3; err_ras=00.
- RAS_DEPTH=4: five nested CALLs -> fifth sets err_ras=10 and advances pc by 1. Then RET on an empty RAS after reset -> err_ras=01, pc=1.
- JMP with stk_data=25 (INST_CAP=20) from pc=7 -> err_tgt=1, pc=8. Also: NEXT at pc=19 -> pc stays 19, or with PC_WRAP_EN pc=0.
- rstn low while in POP -> stk_pop=0 and pc=0 immediately; a stk_valid pulse after release is ignored. HALT -> halted=1, en ignored until reset.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter sequencer for the AZ stack CPU.
//
// Takes one step per accepted `en` request. A step can advance the pc,
// jump unconditionally or on a flag, or CALL/RET through an internal
// return-address stack (RAS). Jump targets come from the data stack over a
// pop/valid handshake, so the stack can take any number of cycles to reply.
//
// Build option:
//   PC_WRAP_EN  when defined, the sequential increment wraps INST_CAP-1 -> 0
//               (pushed return addresses included); otherwise it saturates
//               at INST_CAP-1.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rstn       asynchronous active-low reset
//   en         step request, sampled only in IDLE
//   op[2:0]    000 NEXT, 001 JMP, 010 JZ, 011 JS, 100 CALL, 101 RET,
//              110 HALT, 111 reserved (behaves as NEXT)
//   z_flag     zero flag, sampled in EXEC
//   s_flag     sign flag, sampled in EXEC
//   stk_pop    pop request to the data stack
//   stk_valid  data-stack reply valid, qualifies stk_data
//   stk_data   popped jump target
//   pc         current program counter
//   busy       high in every state other than IDLE
//   done       one-cycle pulse in the cycle the new pc is first visible
//   halted     high in HALTED
//   err_ras    sticky {overflow, underflow}; cleared only by reset
//   err_tgt    sticky, set when a taken target is >= INST_CAP
//   state_dbg  current FSM state (0 IDLE, 1 POP, 2 EXEC, 3 HALTED)
//
// Pop/valid handshake: stk_pop is held high for every cycle spent in POP
// and is the only request. The data stack answers by raising stk_valid
// with the target on stk_data; the word is taken on the first rising edge
// where stk_valid is high, and stk_pop drops in the next cycle. stk_valid
// outside POP carries no meaning and is ignored. There is no back-pressure
// on the reply: the sequencer always accepts it.

module pc_sequencer #(
    parameter int INST_CAP  = 20,
    parameter int ADDR_W    = $clog2(INST_CAP),
    parameter int DATA_LEN  = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [2:0]          op,
    input  logic                z_flag,
    input  logic                s_flag,
    output logic                stk_pop,
    input  logic                stk_valid,
    input  logic [DATA_LEN-1:0] stk_data,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                done,
    output logic                halted,
    output logic [1:0]          err_ras,
    output logic                err_tgt,
    output logic [1:0]          state_dbg
);

    // Target is compared in a width that holds both the raw stack word and
    // INST_CAP, so upper target bits beyond ADDR_W count as out of range.
    localparam int TW = (DATA_LEN > ADDR_W) ? DATA_LEN : ADDR_W;
    localparam int PW = $clog2(RAS_DEPTH + 1);

    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(INST_CAP - 1);
    localparam logic [PW-1:0]     RAS_FULL = PW'(RAS_DEPTH);

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JS   = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    logic [2:0]          op_q;
    logic [DATA_LEN-1:0] target_q;
    logic [ADDR_W-1:0]   ras [RAS_DEPTH];
    logic [PW-1:0]       ras_ptr;

    logic [ADDR_W-1:0] nxt;
    logic [TW:0]       tgt_ext;
    logic              tgt_ok;
    logic [ADDR_W-1:0] tgt_addr;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;

    logic [ADDR_W-1:0] pc_exec;
    logic              do_push;
    logic              do_pop;
    logic              set_ovf;
    logic              set_unf;
    logic              set_tgt;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (en) begin
                    case (op)
                        OP_JMP, OP_JZ, OP_JS, OP_CALL: state_n = S_POP;
                        OP_HALT:                       state_n = S_HALTED;
                        default:                       state_n = S_EXEC;
                    endcase
                end
            end
            S_POP:    if (stk_valid) state_n = S_EXEC;
            S_EXEC:   state_n = S_IDLE;
            S_HALTED: state_n = S_HALTED;
            default:  state_n = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs decoded from state. stk_pop is not registered, so an
    // asynchronous reset drops it immediately.
    // ---------------------------------------------------------------
    always_comb begin
        stk_pop   = (state == S_POP);
        busy      = (state != S_IDLE);
        halted    = (state == S_HALTED);
        state_dbg = state;
    end

    // ---------------------------------------------------------------
    // Datapath helpers
    // ---------------------------------------------------------------
    always_comb begin
`ifdef PC_WRAP_EN
        nxt = (pc == PC_LAST) ? '0 : pc + ADDR_W'(1);
`else
        nxt = (pc == PC_LAST) ? pc : pc + ADDR_W'(1);
`endif
        tgt_ext  = (TW + 1)'(target_q);
        tgt_ok   = (tgt_ext < (TW + 1)'(INST_CAP));
        tgt_addr = tgt_ext[ADDR_W-1:0];

        ras_full  = (ras_ptr == RAS_FULL);
        ras_empty = (ras_ptr == '0);

        // ras_ptr counts entries, so the top of stack is ras[ras_ptr-1].
        ras_top = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (ras_ptr == PW'(i + 1)) ras_top = ras[i];
        end
    end

    // Outcome of the EXEC cycle for the latched op.
    always_comb begin
        pc_exec = nxt;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_tgt = 1'b0;
        case (op_q)
            OP_JMP, OP_JZ, OP_JS: begin
                if ((op_q == OP_JMP) || (op_q == OP_JZ && z_flag) ||
                    (op_q == OP_JS && s_flag)) begin
                    if (tgt_ok) pc_exec = tgt_addr;
                    else        set_tgt = 1'b1;
                end
            end
            OP_CALL: begin
                // A full RAS refuses the call before the target is looked at.
                if (ras_full) begin
                    set_ovf = 1'b1;
                end else if (!tgt_ok) begin
                    set_tgt = 1'b1;
                end else begin
                    do_push = 1'b1;
                    pc_exec = tgt_addr;
                end
            end
            OP_RET: begin
                if (ras_empty) begin
                    set_unf = 1'b1;
                end else begin
                    do_pop  = 1'b1;
                    pc_exec = ras_top;
                end
            end
            default: pc_exec = nxt;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc       <= '0;
            op_q     <= OP_NEXT;
            target_q <= '0;
            ras_ptr  <= '0;
            done     <= 1'b0;
            err_ras  <= 2'b00;
            err_tgt  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else begin
            done <= (state == S_EXEC);
            if (state == S_IDLE && en) op_q <= op;
            if (state == S_POP && stk_valid) target_q <= stk_data;
            if (state == S_EXEC) begin
                pc <= pc_exec;
                if (do_push) ras_ptr <= ras_ptr + PW'(1);
                if (do_pop)  ras_ptr <= ras_ptr - PW'(1);
                if (set_ovf) err_ras[1] <= 1'b1;
                if (set_unf) err_ras[0] <= 1'b1;
                if (set_tgt) err_tgt <= 1'b1;
                for (int i = 0; i < RAS_DEPTH; i++) begin
                    if (do_push && ras_ptr == PW'(i)) ras[i] <= nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int CAP   = 20;
    localparam int AW    = $clog2(CAP);
    localparam int DL    = 8;
    localparam int DEPTH = 4;

    localparam logic [2:0] NEXT = 3'b000, JMP = 3'b001, JZ = 3'b010, JS = 3'b011;
    localparam logic [2:0] CALL = 3'b100, RET = 3'b101, HALT = 3'b110, RSV = 3'b111;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic [2:0]    op = 3'b000;
    logic          z_flag = 1'b0;
    logic          s_flag = 1'b0;
    logic          stk_pop;
    logic          stk_valid = 1'b0;
    logic [DL-1:0] stk_data = '0;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          halted;
    logic [1:0]    err_ras;
    logic          err_tgt;
    logic [1:0]    state_dbg;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int       m_pc;
    int       m_ras[$];
    bit [1:0] m_err_ras;
    bit       m_err_tgt;

    always #5 clk = ~clk;

    pc_sequencer #(
        .INST_CAP (CAP),
        .ADDR_W   (AW),
        .DATA_LEN (DL),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .op       (op),
        .z_flag   (z_flag),
        .s_flag   (s_flag),
        .stk_pop  (stk_pop),
        .stk_valid(stk_valid),
        .stk_data (stk_data),
        .pc       (pc),
        .busy     (busy),
        .done     (done),
        .halted   (halted),
        .err_ras  (err_ras),
        .err_tgt  (err_tgt),
        .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_nxt(input int p);
        if (p < CAP - 1) return p + 1;
`ifdef PC_WRAP_EN
        return 0;
`else
        return p;
`endif
    endfunction

    function automatic void model_reset();
        m_pc = 0;
        m_ras.delete();
        m_err_ras = 2'b00;
        m_err_tgt = 1'b0;
    endfunction

    // One completed step, stated as the programmer sees it.
    function automatic void model_exec(input logic [2:0] o, input int t, input logic z, input logic s);
        int n = model_nxt(m_pc);
        bit in_range = (t < CAP);
        bit taken;
        case (o)
            JMP, JZ, JS: begin
                taken = (o == JMP) || (o == JZ && z) || (o == JS && s);
                if (!taken) m_pc = n;
                else if (!in_range) begin m_err_tgt = 1'b1; m_pc = n; end
                else m_pc = t;
            end
            CALL: begin
                if (m_ras.size() == DEPTH) begin m_err_ras[1] = 1'b1; m_pc = n; end
                else if (!in_range) begin m_err_tgt = 1'b1; m_pc = n; end
                else begin m_ras.push_back(n); m_pc = t; end
            end
            RET: begin
                if (m_ras.size() == 0) begin m_err_ras[0] = 1'b1; m_pc = n; end
                else m_pc = m_ras.pop_back();
            end
            default: m_pc = n;
        endcase
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pop", stk_pop, 0);
        chk("rst_err_ras", err_ras, 0);
        chk("rst_err_tgt", err_tgt, 0);
    endtask

    // Starts and ends 1 time unit after a rising edge with the DUT idle.
    // lat = number of cycles stk_pop is held before stk_valid is returned.
    task automatic step(input logic [2:0] o, input int data, input int lat,
                        input logic z, input logic s);
        bit br = (o == JMP) || (o == JZ) || (o == JS) || (o == CALL);
        en = 1'b1;
        op = o;
        z_flag = z;
        s_flag = s;
        @(posedge clk); #1;
        en = 1'b0;
        op = 3'($urandom);
        if (br) begin
            for (int c = 1; c <= lat; c++) begin
                chk("pop_hi", stk_pop, 1);
                chk("pop_busy", busy, 1);
                if (c == lat) begin
                    stk_valid = 1'b1;
                    stk_data = DL'(data);
                end
                @(posedge clk); #1;
                stk_valid = 1'b0;
                stk_data = DL'($urandom);
            end
        end
        chk("exec_pop_lo", stk_pop, 0);
        chk("exec_busy", busy, 1);
        chk("exec_done", done, 0);
        model_exec(o, data, z, s);
        @(posedge clk); #1;
        chk("step_pc", pc, m_pc);
        chk("step_done", done, 1);
        chk("step_idle", busy, 0);
        chk("step_err_ras", err_ras, m_err_ras);
        chk("step_err_tgt", err_tgt, m_err_tgt);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Three sequential steps
        for (int i = 0; i < 3; i++) begin
            step(NEXT, 0, 1, 1'($urandom), 1'($urandom));
            chk("next_pc", pc, i + 1);
        end

        // JZ taken with a three-cycle stack reply
        step(JZ, 9, 3, 1'b1, 1'b0);
        chk("jz_taken", pc, 9);
        // JZ not taken from pc=4 still pops
        step(JMP, 4, $urandom_range(1, 4), 1'b0, 1'b0);
        step(JZ, $urandom_range(0, CAP - 1), 2, 1'b0, 1'b1);
        chk("jz_not_taken", pc, 5);

        // CALL / NEXT / RET from pc=2
        step(JMP, 2, 1, 1'b0, 1'b0);
        step(CALL, 12, $urandom_range(1, 4), 1'b0, 1'b0);
        chk("call_pc", pc, 12);
        step(NEXT, 0, 1, 1'b0, 1'b0);
        chk("call_next_pc", pc, 13);
        step(RET, 0, 1, 1'b0, 1'b0);
        chk("ret_pc", pc, 3);
        chk("ret_err", err_ras, 2'b00);

        // Five nested calls overflow a four-entry RAS
        for (int i = 0; i < 5; i++) begin
            step(CALL, $urandom_range(0, CAP - 2), $urandom_range(1, 3), 1'b0, 1'b0);
        end
        chk("ras_ovf", err_ras, 2'b10);

        // RET on an empty RAS
        do_reset();
        step(RET, 0, 1, 1'b0, 1'b0);
        chk("ras_unf", err_ras, 2'b01);
        chk("ras_unf_pc", pc, 1);

        // Out-of-range jump target
        step(JMP, 7, 1, 1'b0, 1'b0);
        step(JMP, 25, 2, 1'b0, 1'b0);
        chk("tgt_err", err_tgt, 1);
        chk("tgt_pc", pc, 8);

        // Top of instruction memory
        step(JMP, CAP - 1, 1, 1'b0, 1'b0);
        step(NEXT, 0, 1, 1'b0, 1'b0);
`ifdef PC_WRAP_EN
        chk("top_next", pc, 0);
`else
        chk("top_next", pc, CAP - 1);
`endif

        // Randomized ops against the model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [2:0] o = 3'($urandom);
            if (o == HALT) o = RSV;
            step(o, $urandom_range(0, CAP + 5), $urandom_range(1, 4),
                 1'($urandom), 1'($urandom));
        end

        // Reset while waiting in POP
        step(JMP, 6, 1, 1'b0, 1'b0);
        en = 1'b1;
        op = JMP;
        @(posedge clk); #1;
        en = 1'b0;
        chk("midpop_pop", stk_pop, 1);
        rstn = 1'b0;
        #1;
        chk("midpop_rst_pop", stk_pop, 0);
        chk("midpop_rst_pc", pc, 0);
        chk("midpop_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        stk_valid = 1'b1;
        stk_data = 8'd5;
        @(posedge clk); #1;
        stk_valid = 1'b0;
        chk("late_valid_pc", pc, 0);
        chk("late_valid_busy", busy, 0);
        chk("late_valid_pop", stk_pop, 0);
        @(posedge clk); #1;
        chk("late_valid_done", done, 0);

        // HALT freezes the pc until reset
        step(NEXT, 0, 1, 1'b0, 1'b0);
        en = 1'b1;
        op = HALT;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            op = NEXT;
            stk_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("halt_flag", halted, 1);
            chk("halt_busy", busy, 1);
            chk("halt_pc", pc, 1);
            chk("halt_pop", stk_pop, 0);
        end
        en = 1'b0;
        stk_valid = 1'b0;
        do_reset();
        step(NEXT, 0, 1, 1'b0, 1'b0);
        chk("post_halt_pc", pc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
